// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction/data memory arbiter.
//   arb_state_t : arbiter FSM states
//   arb_src_t   : which client owns the in-flight transaction
//   word_align  : clears the byte offset of a bus address
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_t;

  typedef enum logic {
    SRC_IMEM,
    SRC_DMEM
  } arb_src_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port (imem_*), data port (dmem_*) and unified
// backing-memory bus (bmem_*) around mem_arbiter.
//   slave  : the arbiter's view (client requests and bus responses in)
//   master : the environment's view (core + backing memory)
interface mem_arbiter_if;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata;
  logic        imem_resp;

  logic [31:0] dmem_addr;
  logic [3:0]  dmem_rmask;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;

  logic [31:0] bmem_addr;
  logic        bmem_read;
  logic        bmem_write;
  logic [3:0]  bmem_wmask;
  logic [31:0] bmem_wdata;
  logic        bmem_ready;
  logic [31:0] bmem_rdata;
  logic        bmem_rvalid;

  modport master (
    output imem_addr, imem_rmask, dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
           bmem_ready, bmem_rdata, bmem_rvalid,
    input  imem_rdata, imem_resp, dmem_rdata, dmem_resp,
           bmem_addr, bmem_read, bmem_write, bmem_wmask, bmem_wdata
  );

  modport slave (
    input  imem_addr, imem_rmask, dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
           bmem_ready, bmem_rdata, bmem_rvalid,
    output imem_rdata, imem_resp, dmem_rdata, dmem_resp,
           bmem_addr, bmem_read, bmem_write, bmem_wmask, bmem_wdata
  );
endinterface

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive dmem grants made while a fetch waits.
//   clk, rst : clock, asynchronous active-low reset
//   inc      : a dmem grant happened while imem was requesting
//   clr      : an imem grant happened (takes precedence over inc)
//   at_limit : count has reached STARVE_LIMIT; imem must win next contention
module arb_starve_ctr #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);
  localparam int unsigned   CW      = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);

  logic [CW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != LIMIT_C)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit = (cnt_q == LIMIT_C);
endmodule

// File: rtl/mem_arbiter.sv
// Two-to-one arbiter merging the core's fetch and data ports onto one
// backing-memory bus, one transaction outstanding at a time.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : mem_arbiter_if.slave carrying imem_*, dmem_* and bmem_*
// Data requests win contention until the starvation counter saturates.
// Every output comes straight from a flop.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic         clk,
  input logic         rst,
  mem_arbiter_if.slave bus
);
  arb_state_t  state_d, state_q;
  arb_src_t    src_d, src_q;
  logic [31:0] addr_d, addr_q;
  logic [3:0]  wmask_d, wmask_q;
  logic [31:0] wdata_d, wdata_q;
  logic        read_d, read_q;
  logic        write_d, write_q;
  logic        i_resp_d, i_resp_q;
  logic        d_resp_d, d_resp_q;
  logic [31:0] i_rdata_d, i_rdata_q;
  logic [31:0] d_rdata_d, d_rdata_q;

  logic i_req, d_req, grant_dmem;
  logic starve_inc, starve_clr, at_limit;

  assign i_req      = |bus.imem_rmask;
  assign d_req      = (|bus.dmem_rmask) || (|bus.dmem_wmask);
  assign grant_dmem = d_req && !(i_req && at_limit);

  arb_starve_ctr #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
    .clk      (clk),
    .rst      (rst),
    .inc      (starve_inc),
    .clr      (starve_clr),
    .at_limit (at_limit)
  );

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    addr_d     = addr_q;
    wmask_d    = wmask_q;
    wdata_d    = wdata_q;
    read_d     = read_q;
    write_d    = write_q;
    i_resp_d   = 1'b0;
    d_resp_d   = 1'b0;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
    starve_inc = 1'b0;
    starve_clr = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          state_d = ISSUE;
          if (grant_dmem) begin
            // A non-zero write mask makes it a store even if rmask is also set;
            // wmask_q stays zero for loads and doubles as the store flag later.
            src_d      = SRC_DMEM;
            addr_d     = word_align(bus.dmem_addr);
            wmask_d    = bus.dmem_wmask;
            wdata_d    = bus.dmem_wdata;
            write_d    = |bus.dmem_wmask;
            read_d     = ~(|bus.dmem_wmask);
            starve_inc = i_req;
          end else begin
            src_d      = SRC_IMEM;
            addr_d     = word_align(bus.imem_addr);
            wmask_d    = '0;
            wdata_d    = '0;
            write_d    = 1'b0;
            read_d     = 1'b1;
            starve_clr = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (bus.bmem_ready) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.bmem_rvalid) begin
          state_d = RESP;
          if (src_q == SRC_IMEM) begin
            i_rdata_d = bus.bmem_rdata;
            i_resp_d  = 1'b1;
          end else begin
            d_resp_d = 1'b1;
            if (wmask_q == '0) begin
              d_rdata_d = bus.bmem_rdata;
            end
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      src_q     <= SRC_IMEM;
      addr_q    <= '0;
      wmask_q   <= '0;
      wdata_q   <= '0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      i_resp_q  <= 1'b0;
      d_resp_q  <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      addr_q    <= addr_d;
      wmask_q   <= wmask_d;
      wdata_q   <= wdata_d;
      read_q    <= read_d;
      write_q   <= write_d;
      i_resp_q  <= i_resp_d;
      d_resp_q  <= d_resp_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign bus.bmem_addr  = addr_q;
  assign bus.bmem_wmask = wmask_q;
  assign bus.bmem_wdata = wdata_q;
  assign bus.bmem_read  = read_q;
  assign bus.bmem_write = write_q;
  assign bus.imem_resp  = i_resp_q;
  assign bus.imem_rdata = i_rdata_q;
  assign bus.dmem_resp  = d_resp_q;
  assign bus.dmem_rdata = d_rdata_q;
endmodule
